// File: rtl/itch_feed_arbiter.sv
// rtl/itch_feed_arbiter.sv - packet-atomic round-robin arbiter sharing one itch_parser across N_IN Avalon-ST feeds
module itch_feed_arbiter #(
  parameter int N_IN     = 4,
  parameter int STREAM_W = 64,
  parameter int PORT_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          s_valid,
  output logic [N_IN-1:0]          s_ready,
  input  logic [N_IN*STREAM_W-1:0] s_data,
  input  logic [N_IN-1:0]          s_sop,
  input  logic [N_IN-1:0]          s_eop,
  input  logic [N_IN*3-1:0]        s_empty,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [STREAM_W-1:0]      m_data,
  output logic                     m_sop,
  output logic                     m_eop,
  output logic [2:0]               m_empty,
  output logic [PORT_W-1:0]        m_port,
  output logic                     drop_pulse,
  output logic [15:0]              drop_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [PORT_W-1:0]   grant, grant_nxt;
  logic [PORT_W-1:0]   rr_ptr, rr_nxt;
  logic                drop_pulse_nxt;
  logic [15:0]         drop_cnt_nxt;

  logic [N_IN-1:0]     req;
  logic [N_IN-1:0]     orphan;
  logic [4:0]          orphan_cnt;
  logic [16:0]         drop_sum;
  logic                win_found;
  logic [PORT_W-1:0]   win_idx;

  logic                sel_valid;
  logic [STREAM_W-1:0] sel_data;
  logic                sel_sop;
  logic                sel_eop;
  logic [2:0]          sel_empty;
  logic [N_IN-1:0]     grant_onehot;

  assign req    = s_valid & s_sop;
  assign orphan = s_valid & ~s_sop;
  assign m_port = grant;

  // Round-robin pick: first requester after rr_ptr, wrapping modulo N_IN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_IN; k++) begin
      if (!win_found && req[(int'(rr_ptr) + k) % N_IN]) begin
        win_found = 1'b1;
        win_idx   = PORT_W'((int'(rr_ptr) + k) % N_IN);
      end
    end
  end

  // Count orphan beats seen this cycle and form the saturating drop total
  always_comb begin
    orphan_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      orphan_cnt = orphan_cnt + 5'(orphan[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(orphan_cnt);
  end

  // Select the granted feed's beat fields
  always_comb begin
    sel_valid    = 1'b0;
    sel_data     = '0;
    sel_sop      = 1'b0;
    sel_eop      = 1'b0;
    sel_empty    = '0;
    grant_onehot = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant == PORT_W'(i)) begin
        sel_valid       = s_valid[i];
        sel_data        = s_data[i*STREAM_W +: STREAM_W];
        sel_sop         = s_sop[i];
        sel_eop         = s_eop[i];
        sel_empty       = s_empty[3*i +: 3];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and output decode; reset blocks any handshake in the cycle it is asserted
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    rr_nxt         = rr_ptr;
    drop_pulse_nxt = 1'b0;
    drop_cnt_nxt   = drop_cnt;
    s_ready        = '0;
    m_valid        = 1'b0;
    m_data         = '0;
    m_sop          = 1'b0;
    m_eop          = 1'b0;
    m_empty        = '0;
    case (state)
      IDLE: begin
        // Orphans are swallowed; SOP requesters wait one cycle for the grant
        s_ready        = orphan;
        drop_pulse_nxt = |orphan;
        drop_cnt_nxt   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (win_found) begin
          grant_nxt = win_idx;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        m_valid = sel_valid;
        m_data  = sel_data;
        m_sop   = sel_sop;
        m_eop   = sel_eop;
        m_empty = sel_empty;
        s_ready = grant_onehot & {N_IN{m_ready}};
        if (sel_valid && m_ready && sel_eop) begin
          rr_nxt    = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      s_ready = '0;
      m_valid = 1'b0;
    end
  end

  // State, grant, round-robin pointer and drop statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= PORT_W'(N_IN - 1);
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_nxt;
      drop_pulse <= drop_pulse_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// tb/tb_itch_feed_arbiter.sv - self-checking bench for itch_feed_arbiter
module tb_itch_feed_arbiter;
  localparam int N_IN = 4;
  localparam int SW   = 64;
  localparam int PW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_IN-1:0]      s_valid = '0;
  logic [N_IN-1:0]      s_ready;
  logic [N_IN*SW-1:0]   s_data = '0;
  logic [N_IN-1:0]      s_sop = '0;
  logic [N_IN-1:0]      s_eop = '0;
  logic [N_IN*3-1:0]    s_empty = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [SW-1:0]        m_data;
  logic                 m_sop;
  logic                 m_eop;
  logic [2:0]           m_empty;
  logic [PW-1:0]        m_port;
  logic                 drop_pulse;
  logic [15:0]          drop_cnt;

  itch_feed_arbiter #(.N_IN(N_IN), .STREAM_W(SW), .PORT_W(PW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sop(s_sop),
    .s_eop(s_eop), .s_empty(s_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop),
    .m_eop(m_eop), .m_empty(m_empty), .m_port(m_port),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  typedef struct packed {
    logic [7:0]  port;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } out_t;

  beat_t fq[N_IN][$];
  bit    driven[N_IN];
  bit    mr_q[$];
  bit    mr_default = 1'b1;
  logic [N_IN-1:0] acc = '0;
  out_t  out_q[$];
  out_t  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  // model of the arbiter: owner=-1 means no feed holds the parser
  int m_owner = -1;
  int m_g = 0;
  int m_rr = N_IN - 1;
  int m_cnt = 0;
  bit m_pulse = 1'b0;

  function automatic logic [63:0] mk(input int f, input int m, input int b);
    return 64'hA000_0000_0000_0000 | 64'(f << 16) | 64'(m << 8) | 64'(b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle check of DUT outputs against the model
  always begin
    logic [N_IN-1:0] er;
    logic ev, esop, eeop;
    logic [63:0] ed;
    logic [2:0] eemp;
    int win, orph, j, nx_owner, nx_g, nx_rr, nx_cnt;
    bit nx_pulse;
    @(negedge clk);
    er = '0; ev = 1'b0; ed = '0; esop = 1'b0; eeop = 1'b0; eemp = '0;
    nx_owner = m_owner; nx_g = m_g; nx_rr = m_rr; nx_cnt = m_cnt; nx_pulse = 1'b0;
    if (m_owner < 0) begin
      win = -1;
      orph = 0;
      for (int k = 1; k <= N_IN; k++) begin
        j = (m_rr + k) % N_IN;
        if (win < 0 && s_valid[j] && s_sop[j]) win = j;
      end
      for (int i = 0; i < N_IN; i++) begin
        if (s_valid[i] && !s_sop[i]) begin
          orph++;
          er[i] = 1'b1;
        end
      end
      nx_pulse = (orph > 0);
      nx_cnt = (m_cnt + orph > 65535) ? 65535 : m_cnt + orph;
      if (win >= 0) begin
        nx_owner = win;
        nx_g = win;
      end
    end else begin
      ev = s_valid[m_g];
      ed = s_data[m_g*SW +: SW];
      esop = s_sop[m_g];
      eeop = s_eop[m_g];
      eemp = s_empty[3*m_g +: 3];
      er[m_g] = m_ready;
      if (ev && m_ready && eeop) begin
        nx_owner = -1;
        nx_rr = m_g;
      end
    end
    if (rst) begin
      er = '0; ev = 1'b0;
      nx_owner = -1; nx_g = 0; nx_rr = N_IN - 1; nx_cnt = 0; nx_pulse = 1'b0;
    end
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("s_ready", 64'(s_ready), 64'(er));
    chk("m_port", 64'(m_port), 64'(m_g));
    chk("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    if (ev) begin
      chk("m_data", m_data, ed);
      chk("m_sop", 64'(m_sop), 64'(esop));
      chk("m_eop", 64'(m_eop), 64'(eeop));
      chk("m_empty", 64'(m_empty), 64'(eemp));
    end
    acc = s_valid & s_ready;
    if (m_valid === 1'b1 && m_ready === 1'b1)
      out_q.push_back('{port: 8'(m_port), data: m_data, sop: m_sop, eop: m_eop, empty: m_empty});
    if (drop_pulse === 1'b1) n_pulse++;
    @(posedge clk);
    m_owner = nx_owner; m_g = nx_g; m_rr = nx_rr; m_cnt = nx_cnt; m_pulse = nx_pulse;
  end

  // Feed sources: hold each beat until accepted; bubbles last one cycle
  always begin
    beat_t b;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_IN; i++) begin
      if (driven[i] && fq[i].size() > 0 && (!fq[i][0].vld || acc[i])) void'(fq[i].pop_front());
    end
    for (int i = 0; i < N_IN; i++) begin
      if (fq[i].size() > 0) begin
        b = fq[i][0];
        s_valid[i] = b.vld;
        s_data[i*SW +: SW] = b.data;
        s_sop[i] = b.sop;
        s_eop[i] = b.eop;
        s_empty[3*i +: 3] = b.empty;
        driven[i] = 1'b1;
      end else begin
        s_valid[i] = 1'b0;
        s_sop[i] = 1'b0;
        s_eop[i] = 1'b0;
        driven[i] = 1'b0;
      end
    end
    m_ready = (mr_q.size() > 0) ? mr_q.pop_front() : mr_default;
  end

  task automatic push_msg(input int f, input int m, input int n, input int emp, input int gaps);
    for (int b = 0; b < n; b++) begin
      if ((gaps >> b) & 1) fq[f].push_back('{vld: 1'b0, data: '0, sop: 1'b0, eop: 1'b0, empty: '0});
      fq[f].push_back('{vld: 1'b1, data: mk(f, m, b), sop: (b == 0), eop: (b == n - 1),
                        empty: (b == n - 1) ? 3'(emp) : 3'd0});
    end
  endtask

  task automatic exp_msg(input int f, input int m, input int n, input int emp);
    for (int b = 0; b < n; b++)
      exp_q.push_back('{port: 8'(f), data: mk(f, m, b), sop: (b == 0), eop: (b == n - 1),
                        empty: (b == n - 1) ? 3'(emp) : 3'd0});
  endtask

  task automatic push_orphan(input int f);
    fq[f].push_back('{vld: 1'b1, data: mk(f, 255, 0), sop: 1'b0, eop: 1'b0, empty: '0});
  endtask

  function automatic bit busy();
    for (int i = 0; i < N_IN; i++) if (fq[i].size() > 0) return 1'b1;
    return mr_q.size() > 0;
  endfunction

  task automatic wait_drain(input string nm, input int maxc);
    int c = 0;
    while (busy() && c < maxc) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_drain_timeout"}, 64'(c >= maxc), 64'd0);
  endtask

  task automatic check_seq(input string nm, input int base);
    chk({nm, "_count"}, 64'(out_q.size() - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < out_q.size(); k++) begin
      chk({nm, "_port"}, 64'(out_q[base+k].port), 64'(exp_q[k].port));
      chk({nm, "_data"}, out_q[base+k].data, exp_q[k].data);
      chk({nm, "_sop"}, 64'(out_q[base+k].sop), 64'(exp_q[k].sop));
      chk({nm, "_eop"}, 64'(out_q[base+k].eop), 64'(exp_q[k].eop));
      chk({nm, "_empty"}, 64'(out_q[base+k].empty), 64'(exp_q[k].empty));
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base, c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_m_port", 64'(m_port), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_drop_pulse", 64'(drop_pulse), 64'd0);

    // single 3-beat message from feed 2, empty=5 on last beat
    base = out_q.size();
    push_msg(2, 1, 3, 5, 0);
    exp_msg(2, 1, 3, 5);
    wait_drain("t1", 50);
    check_seq("t1", base);

    // all feeds request together: grants 0,1,2,3,0 then rr sits on 0
    do_reset();
    base = out_q.size();
    push_msg(0, 1, 2, 0, 0); push_msg(0, 2, 2, 0, 0);
    push_msg(1, 1, 2, 0, 0); push_msg(2, 1, 2, 0, 0); push_msg(3, 1, 2, 0, 0);
    exp_msg(0, 1, 2, 0); exp_msg(1, 1, 2, 0); exp_msg(2, 1, 2, 0);
    exp_msg(3, 1, 2, 0); exp_msg(0, 2, 2, 0);
    wait_drain("t2", 100);
    check_seq("t2", base);
    base = out_q.size();
    push_msg(0, 3, 1, 1, 0); push_msg(1, 3, 1, 2, 0);
    exp_msg(1, 3, 1, 2); exp_msg(0, 3, 1, 1);
    wait_drain("t2rr", 50);
    check_seq("t2rr", base);

    // feed 1 locked under backpressure and source gaps, others blocked
    do_reset();
    base = out_q.size();
    push_msg(1, 4, 4, 2, 4'b1010);
    mr_q.push_back(1); mr_q.push_back(1); mr_q.push_back(0); mr_q.push_back(0);
    mr_q.push_back(1); mr_q.push_back(0); mr_q.push_back(1);
    repeat (2) @(negedge clk);
    push_msg(0, 5, 1, 7, 0); push_msg(3, 5, 1, 0, 0);
    exp_msg(1, 4, 4, 2); exp_msg(3, 5, 1, 0); exp_msg(0, 5, 1, 7);
    wait_drain("t3", 100);
    check_seq("t3", base);

    // two orphans in the same idle cycle
    do_reset();
    n_pulse = 0;
    base = out_q.size();
    push_orphan(0); push_orphan(3);
    wait_drain("t4", 20);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_pulses", 64'(n_pulse), 64'd1);
    chk("t4_no_output", 64'(out_q.size()), 64'(base));

    // drive drop_cnt to 0xFFFE, then saturate
    do_reset();
    for (int k = 0; k < 16383; k++) for (int i = 0; i < N_IN; i++) push_orphan(i);
    push_orphan(0); push_orphan(1);
    wait_drain("t5a", 20000);
    chk("t5_cnt_fffe", 64'(drop_cnt), 64'hFFFE);
    push_orphan(2); push_orphan(3);
    wait_drain("t5b", 20);
    chk("t5_cnt_sat", 64'(drop_cnt), 64'hFFFF);
    n_pulse = 0;
    push_orphan(0); push_orphan(1); push_orphan(2);
    wait_drain("t5c", 20);
    chk("t5_cnt_hold", 64'(drop_cnt), 64'hFFFF);
    chk("t5_pulse_sat", 64'(n_pulse), 64'd1);

    // reset on the second beat of a 4-beat message
    do_reset();
    base = out_q.size();
    push_msg(2, 6, 4, 0, 0);
    c = 0;
    while (out_q.size() < base + 1 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk("t6_first_beat_timeout", 64'(c >= 20), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    fq[2].delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_after_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t6_after_rst_s_ready", 64'(s_ready), 64'd0);
    push_msg(2, 7, 2, 0, 0); push_msg(0, 7, 2, 3, 0);
    exp_q.push_back('{port: 8'd2, data: mk(2, 6, 0), sop: 1'b1, eop: 1'b0, empty: 3'd0});
    exp_msg(0, 7, 2, 3); exp_msg(2, 7, 2, 0);
    wait_drain("t6", 50);
    check_seq("t6", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
